rv_lsu_pipe: RTL

RV_LSU_PIPE -- requirements
Module: rv_lsu_pipe

---
 rtl/rv_lsu_pipe_if.sv | 52 +++++
 rtl/rv_lsu_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_lsu_pipe_if.sv
// rv_lsu_pipe_if: request, memory-bus and response signals of the LSU pipe.
//   slave  modport : the LSU (accepts requests, drives the bus, returns responses)
//   master modport : execute stage plus memory bus model on the other side
//   req_*  : request handshake and payload
//   bus_*  : two-phase (address, data) memory bus
//   rsp_*  : completion pulse, extended load data, misalignment fault
interface rv_lsu_pipe_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned LANES = XLEN / 8;

  logic             req_vld;
  logic             req_rdy;
  logic [XLEN-1:0]  req_addr;
  logic [XLEN-1:0]  req_wdata;
  logic             req_we;
  logic [1:0]       req_size;
  logic             req_signed;

  logic             bus_addr_vld;
  logic             bus_addr_rsp;
  logic [XLEN-1:0]  bus_addr;
  logic             bus_we;
  logic [1:0]       bus_size;
  logic [LANES-1:0] bus_be;
  logic             bus_wdata_vld;
  logic             bus_data_rsp;
  logic [XLEN-1:0]  bus_wdata;
  logic [XLEN-1:0]  bus_rdata;

  logic             rsp_vld;
  logic [XLEN-1:0]  rsp_rdata;
  logic             rsp_fault;

  modport slave (
    input  req_vld, req_addr, req_wdata, req_we, req_size, req_signed,
    output req_rdy,
    input  bus_addr_rsp, bus_data_rsp, bus_rdata,
    output bus_addr_vld, bus_addr, bus_we, bus_size, bus_be,
    output bus_wdata_vld, bus_wdata,
    output rsp_vld, rsp_rdata, rsp_fault
  );

  modport master (
    output req_vld, req_addr, req_wdata, req_we, req_size, req_signed,
    input  req_rdy,
    output bus_addr_rsp, bus_data_rsp, bus_rdata,
    input  bus_addr_vld, bus_addr, bus_we, bus_size, bus_be,
    input  bus_wdata_vld, bus_wdata,
    input  rsp_vld, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/rv_lsu_pipe.sv
// rv_lsu_pipe: in-order load/store unit. Requests are queued in a FIFO and
// issued one at a time over a two-phase memory bus; load data is aligned and
// sign/zero extended before the one-cycle completion pulse.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any transaction, empties queue)
//   lsu : rv_lsu_pipe_if.slave (request, bus and response signals)
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned accesses
// without issuing them on the bus; otherwise rsp_fault is tied low.
module rv_lsu_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  rv_lsu_pipe_if.slave  lsu
);
  localparam int unsigned LANES = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(LANES);
  localparam int unsigned PTRW  = $clog2(DEPTH);
  localparam int unsigned CNTW  = PTRW + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            we;
    logic [1:0]      size;
    logic            sgn;
  } req_t;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, RESP = 2'd3} state_t;

  // Double-word requests collapse to word on a 32-bit datapath
  function automatic logic [1:0] eff_size(input logic [1:0] sz);
    return (XLEN == 32 && sz == 2'd3) ? 2'd2 : sz;
  endfunction

  // Lane mask; lanes pushed past the top by a misaligned offset are dropped
  function automatic logic [LANES-1:0] be_calc(input logic [OFFW-1:0] off, input logic [1:0] sz);
    logic [15:0] m;
    m = (16'(1) << (4'(1) << sz)) - 16'(1);
    m = m << off;
    return m[LANES-1:0];
  endfunction

  function automatic logic [XLEN-1:0] rep_wdata(input logic [XLEN-1:0] d, input logic [1:0] sz);
    logic [XLEN-1:0] r;
    unique case (sz)
      2'd0:    r = {LANES{d[7:0]}};
      2'd1:    r = {(LANES/2){d[15:0]}};
      2'd2:    r = {(LANES/4){d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Shift the addressed bytes down, keep 2^size bytes, extend the rest.
  // A full-width access wraps the keep mask to all ones, so it passes unchanged.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rd, input logic [OFFW-1:0] off,
                                               input logic [1:0] sz, input logic sgn);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic [6:0]      nbits;
    logic            sb;
    sh    = rd >> {off, 3'b000};
    nbits = 7'(8) << sz;
    keep  = (XLEN'(1) << nbits) - XLEN'(1);
    unique case (sz)
      2'd0:    sb = sh[7];
      2'd1:    sb = sh[15];
      2'd2:    sb = sh[31];
      default: sb = sh[XLEN-1];
    endcase
    return (sh & keep) | ((sgn && sb) ? ~keep : '0);
  endfunction

  // Request queue
  req_t            mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] cnt_q;
  logic            push, pop;
  req_t            head, in_req;

  assign in_req  = '{addr: lsu.req_addr, wdata: lsu.req_wdata, we: lsu.req_we,
                     size: lsu.req_size, sgn: lsu.req_signed};
  assign lsu.req_rdy = (cnt_q != CNTW'(DEPTH));
  assign push    = lsu.req_vld && lsu.req_rdy;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTRW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTRW'(1);
      cnt_q <= cnt_q + CNTW'(push) - CNTW'(pop);
    end
  end

  // Working register (the request in flight) and registered outputs
  state_t          state_q, state_d;
  logic [XLEN-1:0] wk_addr_q, wk_addr_d;
  logic            wk_we_q, wk_we_d;
  logic [1:0]      wk_size_q, wk_size_d;
  logic            wk_sgn_q, wk_sgn_d;
  logic [LANES-1:0] be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            addr_vld_q, wdata_vld_q, rsp_vld_q;
`ifdef LSU_MISALIGN_TRAP_EN
  logic            fault_q, fault_d;
`endif

  // Next-state and working-register update
  always_comb begin
    state_d   = state_q;
    wk_addr_d = wk_addr_q;
    wk_we_d   = wk_we_q;
    wk_size_d = wk_size_q;
    wk_sgn_d  = wk_sgn_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = '0;
    pop       = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    fault_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (cnt_q != '0) begin
          pop       = 1'b1;
          wk_addr_d = head.addr;
          wk_we_d   = head.we;
          wk_size_d = eff_size(head.size);
          wk_sgn_d  = head.sgn;
          be_d      = be_calc(head.addr[OFFW-1:0], eff_size(head.size));
          wdata_d   = rep_wdata(head.wdata, eff_size(head.size));
`ifdef LSU_MISALIGN_TRAP_EN
          if ((head.addr[2:0] & 3'((4'(1) << eff_size(head.size)) - 4'(1))) != 3'd0) begin
            state_d = RESP;
            fault_d = 1'b1;
          end else begin
            state_d = ADDR;
          end
`else
          state_d = ADDR;
`endif
        end
      end
      ADDR: begin
        if (lsu.bus_addr_rsp) state_d = DATA;
      end
      DATA: begin
        if (lsu.bus_data_rsp) begin
          state_d = RESP;
          rdata_d = wk_we_q ? '0 : load_ext(lsu.bus_rdata, wk_addr_q[OFFW-1:0], wk_size_q, wk_sgn_q);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wk_addr_q   <= '0;
      wk_we_q     <= 1'b0;
      wk_size_q   <= 2'd0;
      wk_sgn_q    <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      addr_vld_q  <= 1'b0;
      wdata_vld_q <= 1'b0;
      rsp_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wk_addr_q   <= wk_addr_d;
      wk_we_q     <= wk_we_d;
      wk_size_q   <= wk_size_d;
      wk_sgn_q    <= wk_sgn_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      addr_vld_q  <= (state_d == ADDR);
      wdata_vld_q <= (state_d == DATA);
      rsp_vld_q   <= (state_d == RESP);
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
  assign lsu.rsp_fault = fault_q;
`else
  assign lsu.rsp_fault = 1'b0;
`endif

  assign lsu.bus_addr_vld  = addr_vld_q;
  assign lsu.bus_addr      = wk_addr_q;
  assign lsu.bus_we        = wk_we_q;
  assign lsu.bus_size      = wk_size_q;
  assign lsu.bus_be        = be_q;
  assign lsu.bus_wdata_vld = wdata_vld_q;
  assign lsu.bus_wdata     = wdata_q;
  assign lsu.rsp_vld       = rsp_vld_q;
  assign lsu.rsp_rdata     = rdata_q;
endmodule
